// File: rtl/interval_sampler.sv
// interval_sampler: staged x/y/z sampler; define INTERVAL_SAMPLER_TRACE_EN to print each stage update.
module interval_sampler #(
  parameter int WIDTH    = 32,
  parameter int INTERVAL = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             done
);
  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(INTERVAL - 1);
  typedef enum logic [2:0] {IDLE, WAIT_X, WAIT_Y, WAIT_Z, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_x, r_y, r_z;
  logic w_zero, w_go, w_acc, w_ydo, w_zdo, w_wait;
  assign w_zero   = r_cnt == '0;
  assign w_go     = r_state == IDLE && start;
  assign in_ready = r_state == WAIT_X && w_zero;
  assign w_acc    = in_ready && in_valid;
  assign w_ydo    = r_state == WAIT_Y && w_zero;
  assign w_zdo    = r_state == WAIT_Z && w_zero;
  assign w_wait   = r_state == WAIT_X || r_state == WAIT_Y || r_state == WAIT_Z;
  assign busy     = r_state != IDLE;
  assign done     = r_state == DONE;
  assign x = r_x;
  assign y = r_y;
  assign z = r_z;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? WAIT_X : IDLE;
      WAIT_X:  w_next = w_acc ? WAIT_Y : WAIT_X;
      WAIT_Y:  w_next = w_zero ? WAIT_Z : WAIT_Y;
      WAIT_Z:  w_next = w_zero ? DONE : WAIT_Z;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_cnt <= RELOAD;
        r_x   <= '0;
        r_y   <= '0;
        r_z   <= '0;
      end else if (w_acc) begin
        r_x   <= in_data;
        r_cnt <= RELOAD;
      end else if (w_ydo) begin
        r_y   <= r_x + WIDTH'(1);
        r_cnt <= RELOAD;
      end else if (w_zdo) begin
        r_z <= r_y + WIDTH'(1);
      end else if (w_wait && !w_zero) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end
`ifdef INTERVAL_SAMPLER_TRACE_EN
  // $strobe reports the values after this edge's non-blocking updates land
  always @(posedge clk) begin
    if (!reset && (w_acc || w_ydo || w_zdo))
      $strobe("%2d: x=%1d y=%1d z=%1d", $time, r_x, r_y, r_z);
    if (!reset && done)
      $display("done");
  end
`else
`endif
endmodule

// File: tb/tb_interval_sampler.sv
// tb_interval_sampler: randomized scoreboard bench for two sampler instances (INTERVAL 10 and 1).
`timescale 1ns/100ps
module tb_interval_sampler;
  logic clk = 0;
  logic reset = 1;
  logic       start[2];
  logic       in_valid[2];
  logic [7:0] in_data[2];
  logic       in_ready[2], busy[2], done[2];
  logic [7:0] x[2], y[2], z[2];
  int cyc = 0;
  int ncmp = 0, nerr = 0;
  typedef struct {int k; int t; int acc; logic [7:0] d;} run_t;
  run_t q[$];
  logic [7:0] held[2][3];

  interval_sampler #(.WIDTH(8), .INTERVAL(10)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .busy(busy[0]), .x(x[0]), .y(y[0]), .z(z[0]), .done(done[0]));
  interval_sampler #(.WIDTH(8), .INTERVAL(1)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .busy(busy[1]), .x(x[1]), .y(y[1]), .z(z[1]), .done(done[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ival(int k);
    return k == 0 ? 10 : 1;
  endfunction

  function automatic void chk(string n, int k, logic [31:0] a, logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", n, k, cyc, a, e);
    end
  endfunction

  // Monitor: the front scoreboard entry defines the expected outputs of its instance
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic eb, er, ed;
      logic [7:0] ex, ey, ez;
      eb = 0; er = 0; ed = 0;
      ex = held[k][0]; ey = held[k][1]; ez = held[k][2];
      if (reset) begin
        held[k][0] = 0; held[k][1] = 0; held[k][2] = 0;
        ex = 0; ey = 0; ez = 0;
      end else if (q.size() > 0 && q[0].k == k && cyc >= q[0].t) begin
        int iv, fin;
        iv = ival(k);
        fin = q[0].acc + 2 * iv;
        eb = cyc <= fin;
        er = cyc >= q[0].t + iv - 1 && cyc < q[0].acc;
        ed = cyc == fin;
        ex = cyc >= q[0].acc ? q[0].d : 8'd0;
        ey = cyc >= q[0].acc + iv ? q[0].d + 8'd1 : 8'd0;
        ez = cyc >= fin ? q[0].d + 8'd2 : 8'd0;
      end
      chk("busy", k, 32'(busy[k]), 32'(eb));
      chk("in_ready", k, 32'(in_ready[k]), 32'(er));
      chk("done", k, 32'(done[k]), 32'(ed));
      chk("x", k, 32'(x[k]), 32'(ex));
      chk("y", k, 32'(y[k]), 32'(ey));
      chk("z", k, 32'(z[k]), 32'(ez));
      if (ed) begin
        held[k][0] = ex; held[k][1] = ey; held[k][2] = ez;
        void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One run: start at the next edge, producer stalls s cycles, optional stray starts while busy
  task automatic run(int k, logic [7:0] d, int s, bit extra);
    int iv, t, acc, fin;
    run_t r;
    iv = ival(k);
    t = cyc + 1;
    acc = t + iv + s;
    fin = acc + 2 * iv;
    r.k = k; r.t = t; r.acc = acc; r.d = d;
    q.push_back(r);
    for (int e = t; e <= fin + 1; e++) begin
      start[k] = (e == t) || (extra && (e == fin + 1 || $urandom_range(0, 3) == 0));
      in_valid[k] = e >= acc;
      in_data[k] = e == acc ? d : 8'($urandom);
      step();
    end
    start[k] = 0;
    in_valid[k] = 0;
    repeat ($urandom_range(1, 3)) step();
  endtask

  task automatic abort(int k, int n);
    run_t r;
    r.k = k; r.t = cyc + 1; r.acc = r.t + ival(k); r.d = 8'($urandom);
    q.push_back(r);
    start[k] = 1;
    in_valid[k] = 1;
    in_data[k] = r.d;
    for (int i = 0; i < n; i++) begin
      step();
      start[k] = 0;
    end
    #1 reset = 1;
    #1;
    chk("abort_x", k, 32'(x[k]), 0);
    chk("abort_y", k, 32'(y[k]), 0);
    chk("abort_z", k, 32'(z[k]), 0);
    chk("abort_busy", k, 32'(busy[k]), 0);
    chk("abort_rdy", k, 32'(in_ready[k]), 0);
    q.delete();
    in_valid[k] = 0;
    step();
    reset = 0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = 0; in_valid[k] = 0; in_data[k] = 0;
      held[k][0] = 0; held[k][1] = 0; held[k][2] = 0;
    end
    repeat (2) step();
    reset = 0;
    repeat (2) step();
    run(0, 8'd5, 0, 0);
    run(0, 8'd9, 4, 0);
    run(0, 8'hFE, 0, 0);
    run(0, 8'h42, 0, 1);
    abort(0, 15);
    run(0, 8'h11, 0, 0);
    run(1, 8'd3, 0, 0);
    run(1, 8'hFF, 2, 1);
    abort(1, 2);
    run(1, 8'h7E, 0, 0);
    for (int i = 0; i < 16; i++)
      run(int'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 5)), 1'($urandom));
    repeat (3) step();
    chk("queue_empty", 0, 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
